// File: rtl/frame_timing_ctrl.sv
// frame_timing_ctrl
//   Raster timing generator for the capture pipeline. Column, row and
//   blanking counters walk each frame as ACTIVE pixels, optional HBLANK
//   gaps after every non-final line and an optional VBLANK tail. Geometry
//   is latched into shadow registers when a run starts. Frames repeat
//   back-to-back until a stop request, which takes effect after the
//   current frame.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-high; forces IDLE and zeroes outputs
//   start        begin a run (sampled in IDLE only)
//   stop         end the run after the current frame (sampled every cycle)
//   cfg_width    active pixels per line   (0 illegal)
//   cfg_height   active lines per frame   (0 illegal)
//   cfg_hblank   blank cycles after each non-final line
//   cfg_vblank   blank cycles after the final line
//   busy         high in every state except IDLE
//   pixel_valid  high in ACTIVE
//   x, y         coordinates of the current pixel
//   line_start   first pixel of each line
//   frame_start  pixel (0,0) of each frame
//   frame_done   final cycle of each frame
//   state_dbg    current FSM state, for checkers
//
// Handshake: there is no backpressure. start is a request that is accepted
// on the rising edge where the block is IDLE and the geometry is legal; the
// first pixel follows one cycle later. stop is a sticky request latched on
// any busy cycle (or together with an accepted start).
module frame_timing_ctrl #(
  parameter int NBITS_X = 11,
  parameter int NBITS_Y = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [NBITS_X-1:0] cfg_width,
  input  logic [NBITS_Y-1:0] cfg_height,
  input  logic [NBITS_X-1:0] cfg_hblank,
  input  logic [NBITS_Y-1:0] cfg_vblank,
  output logic               busy,
  output logic               pixel_valid,
  output logic [NBITS_X-1:0] x,
  output logic [NBITS_Y-1:0] y,
  output logic               line_start,
  output logic               frame_start,
  output logic               frame_done,
  output logic [1:0]         state_dbg
);

  localparam int BW = (NBITS_X > NBITS_Y) ? NBITS_X : NBITS_Y;
  localparam logic [NBITS_X-1:0] ONE_X = 1;
  localparam logic [NBITS_Y-1:0] ONE_Y = 1;
  localparam logic [BW-1:0]      ONE_B = 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HBLANK = 2'd2,
    S_VBLANK = 2'd3
  } state_t;

  state_t             state_q;
  logic [NBITS_X-1:0] x_q;
  logic [NBITS_Y-1:0] y_q;
  logic [BW-1:0]      blank_q;
  logic [NBITS_X-1:0] w_q;
  logic [NBITS_X-1:0] hb_q;
  logic [NBITS_Y-1:0] ht_q;
  logic [NBITS_Y-1:0] vb_q;
  logic               stop_pending_q;

  logic end_of_line;
  logic last_line;
  logic frame_end;

  // Terminal compares use W-1 / Ht-1 so counters never need to reach W or Ht.
  assign end_of_line = (x_q == w_q - ONE_X);
  assign last_line   = (y_q == ht_q - ONE_Y);

  // Final cycle of a frame: last pixel when there is no VBLANK, otherwise
  // the last VBLANK cycle.
  assign frame_end = ((state_q == S_ACTIVE) && end_of_line && last_line &&
                      (vb_q == '0)) ||
                     ((state_q == S_VBLANK) && (blank_q == ONE_B));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      x_q            <= '0;
      y_q            <= '0;
      blank_q        <= '0;
      w_q            <= '0;
      hb_q           <= '0;
      ht_q           <= '0;
      vb_q           <= '0;
      stop_pending_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (start && (cfg_width != '0) && (cfg_height != '0)) begin
        w_q            <= cfg_width;
        ht_q           <= cfg_height;
        hb_q           <= cfg_hblank;
        vb_q           <= cfg_vblank;
        x_q            <= '0;
        y_q            <= '0;
        stop_pending_q <= stop;
        state_q        <= S_ACTIVE;
      end
    end else if (frame_end) begin
      // A stop seen on the final cycle itself still ends the run here.
      x_q            <= '0;
      y_q            <= '0;
      stop_pending_q <= 1'b0;
      state_q        <= (stop_pending_q || stop) ? S_IDLE : S_ACTIVE;
    end else begin
      if (stop) begin
        stop_pending_q <= 1'b1;
      end
      case (state_q)
        S_ACTIVE: begin
          if (end_of_line) begin
            x_q <= '0;
            if (last_line) begin
              // Only reached with V>0; V==0 is handled by frame_end.
              blank_q <= BW'(vb_q);
              state_q <= S_VBLANK;
            end else if (hb_q != '0) begin
              blank_q <= BW'(hb_q);
              state_q <= S_HBLANK;
            end else begin
              y_q <= y_q + ONE_Y;
            end
          end else begin
            x_q <= x_q + ONE_X;
          end
        end
        S_HBLANK: begin
          if (blank_q == ONE_B) begin
            y_q     <= y_q + ONE_Y;
            state_q <= S_ACTIVE;
          end else begin
            blank_q <= blank_q - ONE_B;
          end
        end
        S_VBLANK: begin
          blank_q <= blank_q - ONE_B;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode only from registers, so reset clears them immediately.
  // x_q is held at 0 outside ACTIVE and y_q at 0 in IDLE by the FSM.
  assign busy        = (state_q != S_IDLE);
  assign pixel_valid = (state_q == S_ACTIVE);
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = pixel_valid && (x_q == '0);
  assign frame_start = line_start && (y_q == '0);
  assign frame_done  = frame_end;
  assign state_dbg   = state_q;

endmodule

// File: doc/frame_timing_ctrl.md
Name: frame_timing_ctrl

Overview:
- Sequences column, row and blanking counters to produce raster timing for the capture pipeline.
- Outputs per-pixel coordinates, a valid strobe, and line/frame markers to downstream pixel consumers.
- Configuration is latched at frame start, so a new geometry takes effect only on the next started run.
- Runs frames back-to-back until a stop request is seen; the stop completes the current frame first.

Parameters:
NBITS_X, 11, width of column counter and of cfg_width/cfg_hblank
NBITS_Y, 10, width of row counter and of cfg_height/cfg_vblank

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; forces IDLE immediately
start  in  1  request to begin frames; sampled only in IDLE
stop  in  1  request to halt after the current frame; sampled every cycle
cfg_width  in  NBITS_X  active pixels per line, 0 is illegal
cfg_height  in  NBITS_Y  active lines per frame, 0 is illegal
cfg_hblank  in  NBITS_X  blank cycles after each non-final line
cfg_vblank  in  NBITS_Y  blank cycles after the final line
busy  out  1  high in every state except IDLE
pixel_valid  out  1  high in ACTIVE only
x  out  NBITS_X  column of current pixel
y  out  NBITS_Y  row of current pixel
line_start  out  1  high on x==0 pixel of each line
frame_start  out  1  high on pixel (0,0) of each frame
frame_done  out  1  one-cycle pulse on the final cycle of each frame

Behaviour:
- Interface: one clock, clock; reset is asynchronous and active-high, port reset.
- Reset (asserted at any time, including mid-frame):
  - state=IDLE, shadow cfg=0, stop_pending=0.
  - All outputs 0 immediately, without waiting for a clock edge.
- States: IDLE, ACTIVE, HBLANK, VBLANK. All outputs decode from registered state and counters only; no input-to-output combinational path.
- IDLE:
  - start=1 with cfg_width!=0 and cfg_height!=0: latch all four cfg inputs into shadow registers, clear x/y, go to ACTIVE. The first pixel appears the cycle after start is sampled (latency 1).
  - start=1 with zero width or height: ignored; remain IDLE, busy stays 0.
  - stop alone: ignored.
  - start and stop in the same cycle: exactly one frame, then IDLE.
- ACTIVE:
  - pixel_valid=1; x increments by 1 each cycle.
  - At x==W-1, non-final line:
    - H>0: go to HBLANK, load blank counter with H.
    - H==0: stay in ACTIVE, x=0, y+1.
  - At x==W-1, final line (y==Ht-1):
    - V>0: go to VBLANK, load blank counter with V.
    - V==0: frame ends on this cycle.
- HBLANK: decrements the blank counter; after H cycles go to ACTIVE with x=0, y+1.
- VBLANK: decrements the blank counter; its last cycle is the frame's final cycle.
- HBLANK is never inserted after the final line.
- Frame length in cycles: Ht*(W+H) - H + V.
- Final cycle of a frame: frame_done=1. Then:
  - stop_pending=1: go to IDLE, clear stop_pending.
  - Otherwise: next cycle is pixel (0,0) of a new frame using the same shadow cfg.
- stop_pending is set by stop=1 in any busy cycle. A stop on the final cycle itself also ends the run after that frame.
- start while busy is ignored. cfg inputs are ignored while busy.
- Outside ACTIVE:
  - x=0.
  - y holds the current row in HBLANK, Ht-1 in VBLANK, and 0 in IDLE.
- Width and counter rules:
  - All arithmetic is unsigned; counters never wrap, because the terminal compare uses W-1 and Ht-1.
  - Maximum legal values are W=2^NBITS_X-1 and Ht=2^NBITS_Y-1.
  - The blank counter is max(NBITS_X,NBITS_Y) bits wide.

Test Plan:
- W=4, Ht=3, H=2, V=3; start pulse then stop one cycle later -> busy for exactly 19 cycles:
  - pixel_valid on 12 cycles.
  - line_start at offsets 0, 6, 12.
  - frame_start at offset 0 only.
  - frame_done at offset 18, then IDLE with all outputs 0.
- Same cfg, no stop, then stop asserted at offset 25 -> two frames, busy for 38 cycles:
  - second frame_start at offset 19.
  - frame_done at offsets 18 and 37.
- W=3, Ht=2, H=0, V=0; start and stop together -> 6 consecutive valid cycles, coords (0,0)..(2,1), frame_done on cycle 6, then IDLE.
- start with cfg_width=0 -> busy never asserts. Changing cfg while busy -> running frame geometry unchanged.
- Assert reset mid-HBLANK with no clock edge -> busy, pixel_valid, x, y drop to 0 immediately. After release, a start pulse produces (0,0) one cycle later.
- W=2047, Ht=1, H=5, V=1 -> x reaches 2047-1=2046 without wrapping, no HBLANK inserted, frame_done at offset 2047.
